// File: rtl/sseg_scan_pkg.sv
// rtl/sseg_scan_pkg.sv - shared constants, types and helpers for the seven-segment scanner
package sseg_scan_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int POS_W      = 3;
  localparam int BCD_W      = 4;
  localparam int DIGIT_W    = 5;
  localparam int BCD_BUS_W  = NUM_DIGITS * BCD_W;

  localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [POS_W-1:0] LAST_POS = 3'd5;

  // One full display frame: digits, dp enables and dp blink enables
  typedef struct packed {
    logic [BCD_BUS_W-1:0]  bcd;
    logic [NUM_DIGITS-1:0] dp;
    logic [NUM_DIGITS-1:0] blink;
  } frame_t;

  // Position 0 is the leftmost digit and lives in the top nibble
  function automatic logic [BCD_W-1:0] bcd_nibble(input logic [BCD_BUS_W-1:0] bcd,
                                                  input logic [POS_W-1:0] pos);
    int idx;
    idx = NUM_DIGITS - 1 - int'(pos);
    if (idx < 0) return '0;
    return bcd[idx*BCD_W +: BCD_W];
  endfunction

  // Flag vectors use the same left-to-right ordering: bit 5 is position 0
  function automatic logic flag_bit(input logic [NUM_DIGITS-1:0] flags,
                                    input logic [POS_W-1:0] pos);
    int idx;
    idx = NUM_DIGITS - 1 - int'(pos);
    if (idx < 0) return 1'b0;
    return flags[idx];
  endfunction

endpackage

// File: rtl/sseg_tick_div.sv
// rtl/sseg_tick_div.sv - modulo-N enabled counter with a single-cycle tick on its last count
module sseg_tick_div #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == LAST);

  // Advance on enable, wrapping to zero on the tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/sseg_scan.sv
// rtl/sseg_scan.sv - double-buffered six-digit seven-segment scan controller
module sseg_scan
  import sseg_scan_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int DIGIT_HZ = 1000,
  parameter int BLINK_HZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BCD_BUS_W-1:0]  bcd_in,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic [NUM_DIGITS-1:0] dp_blink,
  input  logic                  load,
  output logic [DIGIT_W-1:0]    digit,
  output logic [POS_W-1:0]      digit_pos,
  output logic                  frame_start,
  output logic                  applied
);

  localparam int DIV         = CLK_HZ / DIGIT_HZ;
  localparam int BLINK_TICKS = DIGIT_HZ / (2 * BLINK_HZ);

  logic   tick;
  logic   blink_wrap;
  logic   blink_phase;
  logic   last_pos;
  logic   swap;
  logic   pending_valid;
  frame_t pending;
  frame_t shadow;
  frame_t shadow_nxt;
  logic [POS_W-1:0]   pos_nxt;
  logic [BCD_W-1:0]   nib_nxt;
  logic [DIGIT_W-1:0] digit_nxt;

  sseg_tick_div #(.N(DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .tick  (tick)
  );

  sseg_tick_div #(.N(BLINK_TICKS)) u_blink_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick),
    .tick  (blink_wrap)
  );

  assign last_pos = (digit_pos == LAST_POS);
  assign swap     = tick && last_pos && pending_valid;

  // Next position and next shadow so digit and digit_pos move as an aligned pair
  always_comb begin
    pos_nxt    = digit_pos;
    shadow_nxt = shadow;
    if (tick) begin
      pos_nxt = last_pos ? '0 : digit_pos + 1'b1;
    end
    if (swap) begin
      shadow_nxt = pending;
    end
  end

  // Out-of-range nibbles become 0 since the decoder has nothing defined above 9
  always_comb begin
    nib_nxt = bcd_nibble(shadow_nxt.bcd, pos_nxt);
    if (nib_nxt > BCD_MAX) begin
      nib_nxt = '0;
    end
    digit_nxt = {flag_bit(shadow_nxt.dp, pos_nxt) &
                 ~(flag_bit(shadow_nxt.blink, pos_nxt) & blink_phase),
                 nib_nxt};
  end

  // Scan position, displayed digit and the per-frame strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_pos   <= '0;
      digit       <= '0;
      frame_start <= 1'b0;
      applied     <= 1'b0;
    end else begin
      frame_start <= tick && last_pos;
      applied     <= swap;
      if (tick) begin
        digit_pos <= pos_nxt;
        digit     <= digit_nxt;
      end
    end
  end

  // Pending/shadow double buffer; a load on the swap edge refills pending and keeps it valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending       <= '0;
      shadow        <= '0;
      pending_valid <= 1'b0;
    end else begin
      shadow <= shadow_nxt;
      if (load) begin
        pending       <= '{bcd: bcd_in, dp: dp_in, blink: dp_blink};
        pending_valid <= 1'b1;
      end else if (swap) begin
        pending_valid <= 1'b0;
      end
    end
  end

  // Blink phase flips each time the blink divider wraps; 0 means dp visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_phase <= 1'b0;
    end else if (blink_wrap) begin
      blink_phase <= ~blink_phase;
    end
  end

endmodule

// File: tb/tb_sseg_scan.sv
// tb/tb_sseg_scan.sv - randomized self-checking bench for sseg_scan against a tick-count reference model
module tb_sseg_scan;

  localparam int CLK_HZ   = 24;
  localparam int DIGIT_HZ = 6;
  localparam int BLINK_HZ = 1;
  localparam int DIV      = CLK_HZ / DIGIT_HZ;
  localparam int BT       = DIGIT_HZ / (2 * BLINK_HZ);

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [23:0] bcd_in = '0;
  logic [5:0]  dp_in = '0;
  logic [5:0]  dp_blink = '0;
  logic        load = 1'b0;
  logic [4:0]  digit;
  logic [2:0]  digit_pos;
  logic        frame_start;
  logic        applied;

  int errors = 0;
  int checks = 0;

  sseg_scan #(.CLK_HZ(CLK_HZ), .DIGIT_HZ(DIGIT_HZ), .BLINK_HZ(BLINK_HZ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bcd_in      (bcd_in),
    .dp_in       (dp_in),
    .dp_blink    (dp_blink),
    .load        (load),
    .digit       (digit),
    .digit_pos   (digit_pos),
    .frame_start (frame_start),
    .applied     (applied)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: everything derives from clocks and ticks elapsed since reset release
  int          m_cyc;
  int          m_ticks;
  logic [23:0] m_pb, m_sb;
  logic [5:0]  m_pd, m_pbl, m_sd, m_sbl;
  bit          m_pv;
  logic [4:0]  m_digit;
  bit          m_fs, m_ap;

  function automatic logic [4:0] show(input logic [23:0] bcd, input logic [5:0] dp,
                                      input logic [5:0] bl, input int pos, input int phase);
    logic [23:0] t;
    logic [3:0]  nib;
    t   = bcd >> (4 * (5 - pos));
    nib = t[3:0];
    if (nib > 4'd9) nib = 4'd0;
    return {dp[5-pos] & ~(bl[5-pos] & (phase == 1)), nib};
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_ticks = 0; m_pv = 0;
    m_pb = '0; m_sb = '0; m_pd = '0; m_pbl = '0; m_sd = '0; m_sbl = '0;
    m_digit = '0; m_fs = 0; m_ap = 0;
  endtask

  task automatic model_step();
    bit swap;
    swap = 0;
    m_fs = 0;
    m_ap = 0;
    m_cyc++;
    if (m_cyc % DIV == 0) begin
      if (m_ticks % 6 == 5) begin
        m_fs = 1;
        if (m_pv) begin
          swap = 1;
          m_ap = 1;
          m_sb = m_pb; m_sd = m_pd; m_sbl = m_pbl;
        end
      end
      m_ticks++;
      m_digit = show(m_sb, m_sd, m_sbl, m_ticks % 6, ((m_ticks - 1) / BT) % 2);
    end
    if (load) begin
      m_pb = bcd_in; m_pd = dp_in; m_pbl = dp_blink; m_pv = 1;
    end else if (swap) begin
      m_pv = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // Cycle-by-cycle comparison, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("digit", digit, m_digit);
      check("digit_pos", digit_pos, m_ticks % 6);
      check("frame_start", frame_start, m_fs);
      check("applied", applied, m_ap);
    end
  end

  task automatic do_load(input logic [23:0] b, input logic [5:0] d, input logic [5:0] bl);
    bcd_in = b; dp_in = d; dp_blink = bl; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_applied(input string tag, input int budget);
    int n;
    n = 0;
    while (!applied && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, applied, 1'b1);
  endtask

  initial begin
    int cnt;
    int n;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_digit", digit, 5'd0);
    check("rst_pos", digit_pos, 3'd0);
    check("rst_strobes", {frame_start, applied}, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle scan: no applied pulses, frame_start once per 24 clocks
    cnt = 0; n = 0;
    for (int i = 0; i < 72; i++) begin
      @(negedge clk);
      cnt += applied;
      n += frame_start;
    end
    check("idle_applied_cnt", cnt, 0);
    check("idle_frame_cnt", n, 3);

    // Mid-frame load shows 1..6 with dp only at position 3
    n = 0;
    while (m_ticks % 6 != 2 && n < 100) begin @(negedge clk); n++; end
    do_load(24'h123456, 6'b000100, 6'b000000);
    wait_applied("s1_applied", 60);
    for (int p = 0; p < 6; p++) begin
      check("s1_pos", digit_pos, p);
      check("s1_digit", digit, {p == 3, 4'(p + 1)});
      repeat (DIV) @(negedge clk);
    end

    // Two loads in one frame: last wins, single applied
    do_load(24'h111111, 6'h00, 6'h00);
    do_load(24'h999999, 6'h00, 6'h00);
    cnt = 0;
    for (int i = 0; i < 2 * 6 * DIV; i++) begin
      @(negedge clk);
      cnt += applied;
    end
    check("s2_applied_cnt", cnt, 1);
    check("s2_digit", digit[3:0], 4'd9);

    // Load exactly on the swap edge
    do_load(24'h222222, 6'h00, 6'h00);
    n = 0;
    while (!(m_ticks % 6 == 5 && (m_cyc + 1) % DIV == 0) && n < 100) begin @(negedge clk); n++; end
    do_load(24'h000000, 6'h00, 6'h00);
    check("s3_applied", applied, 1'b1);
    check("s3_digit_old", digit, 5'h02);
    @(negedge clk);
    wait_applied("s3_applied2", 6 * DIV + 2);
    check("s3_digit_new", digit, 5'h00);

    // Out-of-range nibbles and dp blink
    do_load(24'hA0F909, 6'h3F, 6'b100000);
    wait_applied("s4_applied", 6 * DIV + 2);
    for (int p = 0; p < 6; p++) begin
      if (p == 2) check("s4_pos2_digit", digit[3:0], 4'd0);
      if (p == 0) check("s4_pos0_digit", digit[3:0], 4'd0);
      if (p != 0) check("s4_dp_on", digit[4], 1'b1);
      repeat (DIV) @(negedge clk);
    end
    repeat (6 * 6 * DIV) @(negedge clk);

    // Random loads, including ones that land on swap edges
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0)
        do_load(24'($urandom), 6'($urandom), 6'($urandom));
      else
        @(negedge clk);
    end

    // Asynchronous reset mid-dwell at position 3
    n = 0;
    while (!(m_ticks % 6 == 3 && m_cyc % DIV == 1) && n < 100) begin @(negedge clk); n++; end
    #2 rst_n = 1'b0;
    #1;
    check("arst_digit", digit, 5'd0);
    check("arst_pos", digit_pos, 3'd0);
    check("arst_strobes", {frame_start, applied}, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3 * 6 * DIV; i++) begin
      @(negedge clk);
      cnt += applied;
      if (digit !== 5'd0) cnt += 100;
    end
    check("arst_after", cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
